// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display controller.
// Holds the segment codes, the converter state type and constant helpers.
package fnd_pkg;

    // Active-low segment codes, bits[6:0] = g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Largest value that fits in the given number of decimal digits
    function automatic logic [31:0] pow10_minus1(input int digits);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < 9; i++) begin
            if (i < digits) p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/fnd_display_ctrl_bin2bcd.sv
// Sequential binary to BCD converter using shift-add-3, one input bit per cycle.
// Digits above DIGITS are dropped, so the result is the value modulo 10^DIGITS.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(WIDTH);

    conv_state_t         r_state;
    conv_state_t         w_nextState;
    logic [WIDTH-1:0]    r_shift;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_adj;
    logic [CNT_W-1:0]    r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(WIDTH - 1)) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd   <= {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign bcd_out = r_bcd;

endmodule

// File: rtl/fnd_display_ctrl.sv
// Multiplexed 7-segment display controller: sequential BCD conversion feeding
// a held display register that is scanned one digit per TICK_DIV clocks.
module fnd_display_ctrl
    import fnd_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  bin_in,
    input  logic              bin_valid,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] fnd_digit,
    output logic [7:0]        fnd_data
);

    localparam logic [31:0] OVF_LIMIT = pow10_minus1(DIGITS);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                w_start;
    logic                w_done;
    logic [4*DIGITS-1:0] w_bcd;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_ovf;
    logic                r_ovfNext;
    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_fndDigit;
    logic [7:0]          r_fndData;
    logic [3:0]          w_nibble;
    logic                w_upperZero;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_digitSel;

    assign w_start = bin_valid & ~busy;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .bin_in  (bin_in),
        .start   (w_start),
        .busy    (busy),
        .done    (w_done),
        .bcd_out (w_bcd)
    );

    // Overflow is judged on the raw input at acceptance and published with the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovfNext <= 1'b0;
            r_ovf     <= 1'b0;
            r_disp    <= '0;
        end else begin
            if (w_start) r_ovfNext <= (32'(bin_in) > OVF_LIMIT);
            if (w_done) begin
                r_disp <= w_bcd;
                r_ovf  <= r_ovfNext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(TICK_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        w_nibble    = r_disp[4*r_idx +: 4];
        w_upperZero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(r_idx) && r_disp[4*i +: 4] != 4'd0) w_upperZero = 1'b0;
        end
        if (r_ovf)
            w_seg = SEG_DASH;
        else if (blank_lz && r_idx != '0 && w_upperZero)
            w_seg = SEG_BLANK;
        else
            w_seg = seg7_decode(w_nibble);
        w_digitSel = ~(DIGITS'(1) << r_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fndDigit <= '1;
            r_fndData  <= 8'hFF;
        end else begin
            r_fndDigit <= w_digitSel;
            r_fndData  <= {~dp_mask[r_idx], w_seg};
        end
    end

    assign ovf       = r_ovf;
    assign fnd_digit = r_fndDigit;
    assign fnd_data  = r_fndData;

endmodule
